// File: rtl/counter_ctrl_if.sv
// Front-panel bundle between the panel controller and the counter/display side:
// raw active-low buttons in, counter control and display strobes out.
interface counter_ctrl_if;
   logic       S1;
   logic       S2;
   logic       S3;
   logic       S4;
   logic       tick;
   logic       ce;
   logic       clr;
   logic       up;
   logic       L;
   logic [3:0] di;
   logic       fast;
   logic       blink;

   modport master (
      input  S1, S2, S3, S4,
      output tick, ce, clr, up, L, di, fast, blink
   );

   modport slave (
      output S1, S2, S3, S4,
      input  tick, ce, clr, up, L, di, fast, blink
   );
endinterface

// File: rtl/counter_ctrl.sv
// Front-panel controller: button conditioning, run/stop/edit/load sequencing and
// step-tick generation for the board's 16-bit up/down counter.
module counter_ctrl #(
   parameter int DEB_CYCLES = 480000,
   parameter int TICK_FAST  = 9000,
   parameter int TICK_SLOW  = 48000000,
   parameter int CNT_W      = 26
) (
   input  logic           CLK,
   input  logic           RST_N,
   counter_ctrl_if.master pnl
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] TERM_FAST = CNT_W'(TICK_FAST);
   localparam logic [CNT_W-1:0] TERM_SLOW = CNT_W'(TICK_SLOW);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_EDIT = 2'd2,
      ST_LOAD = 2'd3
   } state_e;

   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       acc_q, acc_d;
   logic [DEB_W-1:0] deb_cnt_q [4];
   logic [DEB_W-1:0] deb_cnt_d [4];
   logic [3:0]       press_q, press_d;
   logic [CNT_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] term_s;
   logic             tick_s;
   state_e           state_q, state_d;
   logic             ce_q, ce_d;
   logic             clr_q, clr_d;
   logic             clr_set_s;
   logic             up_q, up_d;
   logic             l_q, l_d;
   logic [3:0]       di_q, di_d;
   logic             fast_q, fast_d;
   logic             blink_q, blink_d;

   // Button synchronisers and per-button debounce; bit order is {S4,S3,S2,S1}.
   always_comb begin
      sync1_d = {pnl.S4, pnl.S3, pnl.S2, pnl.S1};
      sync2_d = sync1_q;
      acc_d   = acc_q;
      press_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (sync2_q[i] == acc_q[i]) begin
            deb_cnt_d[i] = {DEB_W{1'b0}};
         end else if (deb_cnt_q[i] == DEB_MAX) begin
            deb_cnt_d[i] = {DEB_W{1'b0}};
            acc_d[i]     = sync2_q[i];
            press_d[i]   = ~sync2_q[i];
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
         end
      end
   end

   // Prescaler; an out-of-range count after a rate change restarts silently.
   always_comb begin
      term_s = fast_q ? TERM_FAST : TERM_SLOW;
      tick_s = (pre_q == term_s);
      if (pre_q >= term_s) begin
         pre_d = {CNT_W{1'b0}};
      end else begin
         pre_d = pre_q + CNT_W'(1);
      end
   end

   // Panel FSM; each arm honours S1 > S4 > S2 > S3 among the presses it accepts.
   always_comb begin
      state_d   = state_q;
      up_d      = up_q;
      di_d      = di_q;
      fast_d    = fast_q;
      clr_set_s = 1'b0;
      case (state_q)
         ST_STOP: begin
            if (press_q[0]) begin
               state_d = ST_RUN;
            end else if (press_q[3]) begin
               state_d = ST_EDIT;
            end else if (press_q[1]) begin
               clr_set_s = 1'b1;
            end else if (press_q[2]) begin
               up_d = ~up_q;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_RUN: begin
            if (press_q[0]) begin
               state_d = ST_STOP;
            end else if (press_q[1]) begin
               clr_set_s = 1'b1;
            end else if (press_q[2]) begin
               up_d = ~up_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_EDIT: begin
            if (press_q[0]) begin
               state_d = ST_STOP;
            end else if (press_q[3]) begin
               state_d = ST_LOAD;
            end else if (press_q[1]) begin
               fast_d = ~fast_q;
            end else if (press_q[2]) begin
               di_d = di_q + 4'd1;
            end else begin
               state_d = ST_EDIT;
            end
         end
         ST_LOAD: begin
            if (tick_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase

      // A pending clear lives through the next tick; it is dropped rather than overlap a load.
      if (state_d == ST_LOAD) begin
         clr_d = 1'b0;
      end else if (clr_set_s) begin
         clr_d = 1'b1;
      end else if (tick_s) begin
         clr_d = 1'b0;
      end else begin
         clr_d = clr_q;
      end

      ce_d    = (state_d == ST_RUN);
      l_d     = (state_d == ST_LOAD);
      blink_d = (state_d == ST_EDIT);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         acc_q   <= 4'hF;
         press_q <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= {DEB_W{1'b0}};
         end
         pre_q   <= {CNT_W{1'b0}};
         state_q <= ST_STOP;
         ce_q    <= 1'b0;
         clr_q   <= 1'b0;
         up_q    <= 1'b1;
         l_q     <= 1'b0;
         di_q    <= 4'h0;
         fast_q  <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         acc_q   <= acc_d;
         press_q <= press_d;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         pre_q   <= pre_d;
         state_q <= state_d;
         ce_q    <= ce_d;
         clr_q   <= clr_d;
         up_q    <= up_d;
         l_q     <= l_d;
         di_q    <= di_d;
         fast_q  <= fast_d;
         blink_q <= blink_d;
      end
   end

   assign pnl.tick  = tick_s;
   assign pnl.ce    = ce_q;
   assign pnl.clr   = clr_q;
   assign pnl.up    = up_q;
   assign pnl.L     = l_q;
   assign pnl.di    = di_q;
   assign pnl.fast  = fast_q;
   assign pnl.blink = blink_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with short debounce and tick periods: button-press vectors
// checked through a scoreboard queue, plus hand sequences for tick/clr/L timing and reset.
module tb_counter_ctrl;

   localparam int DEB = 4;
   localparam int TF  = 3;
   localparam int TS  = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   counter_ctrl_if pnl ();

   counter_ctrl #(
      .DEB_CYCLES (DEB),
      .TICK_FAST  (TF),
      .TICK_SLOW  (TS),
      .CNT_W      (26)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .pnl   (pnl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      int         reps;
      logic       ce;
      logic       up;
      logic [3:0] di;
      logic       fast;
      logic       blink;
   } vec_t;

   vec_t vecs [$];
   vec_t sb   [$];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // mask bit i high means button S(i+1) is pressed (line driven low)
   task automatic drive(input logic [3:0] m);
      pnl.S1 = ~m[0];
      pnl.S2 = ~m[1];
      pnl.S3 = ~m[2];
      pnl.S4 = ~m[3];
   endtask

   task automatic press(input logic [3:0] m);
      drive(m);
      repeat (DEB + 3) cyc();
      drive(4'b0000);
      repeat (DEB + 4) cyc();
   endtask

   task automatic add(input logic [3:0] m, input int r, input logic ce, input logic up,
                      input logic [3:0] di, input logic fast, input logic blink);
      vec_t v;
      v.mask = m; v.reps = r; v.ce = ce; v.up = up; v.di = di; v.fast = fast; v.blink = blink;
      vecs.push_back(v);
   endtask

   task automatic run_vectors(input int first, input int last);
      vec_t e;
      for (int i = first; i <= last; i++) begin
         sb.push_back(vecs[i]);
         for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].mask);
         e = sb.pop_front();
         chk($sformatf("v%0d_ce", i),    pnl.ce,    e.ce);
         chk($sformatf("v%0d_up", i),    pnl.up,    e.up);
         chk($sformatf("v%0d_di", i),    pnl.di,    e.di);
         chk($sformatf("v%0d_fast", i),  pnl.fast,  e.fast);
         chk($sformatf("v%0d_blink", i), pnl.blink, e.blink);
         chk($sformatf("v%0d_L", i),     pnl.L,     0);
      end
   endtask

   task automatic check_period(input string nm, input int exp);
      int n;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (pnl.tick) seen = 1'b1;
      end
      chk({nm, "_first_tick"}, seen, 1);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         n++;
         if (pnl.tick) seen = 1'b1;
      end
      chk({nm, "_period"}, n, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      drive(4'b0000);
      rst_n = 1'b0;
      // S1=run, S2=clear/speed, S3=dir/inc, S4=edit/commit; bit0 = S1
      add(4'b0100, 1,  1'b1, 1'b0, 4'h0, 1'b0, 1'b0); // RUN: direction down
      add(4'b0001, 1,  1'b0, 1'b0, 4'h0, 1'b0, 1'b0); // STOP
      add(4'b0100, 1,  1'b0, 1'b1, 4'h0, 1'b0, 1'b0); // direction up
      add(4'b1000, 1,  1'b0, 1'b1, 4'h0, 1'b0, 1'b1); // EDIT
      add(4'b0100, 17, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1); // di wraps past F
      add(4'b0010, 1,  1'b0, 1'b1, 4'h1, 1'b1, 1'b1); // fast on
      add(4'b0101, 1,  1'b1, 1'b1, 4'h1, 1'b1, 1'b0); // S1+S3 same cycle: only S1
      add(4'b0001, 1,  1'b0, 1'b1, 4'h1, 1'b1, 1'b0); // STOP
      add(4'b1000, 1,  1'b0, 1'b1, 4'h1, 1'b1, 1'b1); // EDIT
      add(4'b0001, 1,  1'b0, 1'b1, 4'h1, 1'b1, 1'b0); // cancel, di kept
      add(4'b1000, 1,  1'b0, 1'b1, 4'h1, 1'b1, 1'b1); // EDIT again

      repeat (3) cyc();
      chk("rst_tick",  pnl.tick,  0);
      chk("rst_ce",    pnl.ce,    0);
      chk("rst_up",    pnl.up,    1);
      chk("rst_clr",   pnl.clr,   0);
      chk("rst_L",     pnl.L,     0);
      chk("rst_di",    pnl.di,    0);
      chk("rst_fast",  pnl.fast,  0);
      chk("rst_blink", pnl.blink, 0);
      rst_n = 1'b1;
      check_period("slow", TS + 1);
      chk("idle_ce", pnl.ce, 0);

      // 3-sample glitch is rejected
      drive(4'b0001);
      repeat (3) cyc();
      drive(4'b0000);
      repeat (10) cyc();
      chk("glitch_ce", pnl.ce, 0);

      // genuine press: ce on the 7th edge counting the first low sample
      drive(4'b0001);
      repeat (6) cyc();
      chk("s1_ce_early", pnl.ce, 0);
      cyc();
      chk("s1_ce_at7", pnl.ce, 1);
      repeat (3) cyc();
      drive(4'b0000);
      repeat (DEB + 4) cyc();
      chk("s1_release_ce", pnl.ce, 1);

      // clear request in RUN
      drive(4'b0010);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (pnl.clr) seen = 1'b1;
      end
      chk("clr_rise", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (pnl.tick) begin
            chk("clr_at_tick", pnl.clr, 1);
            cyc();
            chk("clr_after_tick", pnl.clr, 0);
            seen = 1'b1;
         end else begin
            chk("clr_hold", pnl.clr, 1);
            cyc();
         end
      end
      chk("clr_tick_seen", seen, 1);
      chk("clr_ce", pnl.ce, 1);
      drive(4'b0000);
      repeat (DEB + 4) cyc();

      run_vectors(0, 5);
      check_period("fast", TF + 1);

      // commit: L held through the next tick, then STOP
      drive(4'b1000);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (pnl.L) seen = 1'b1;
      end
      chk("load_rise", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         chk("load_no_clr", pnl.clr, 0);
         if (pnl.tick) begin
            chk("L_at_tick", pnl.L, 1);
            cyc();
            chk("L_after_tick", pnl.L, 0);
            chk("load_blink", pnl.blink, 0);
            chk("load_ce", pnl.ce, 0);
            seen = 1'b1;
         end else begin
            chk("L_hold", pnl.L, 1);
            cyc();
         end
      end
      chk("load_tick_seen", seen, 1);
      drive(4'b0000);
      repeat (DEB + 4) cyc();

      run_vectors(6, 10);

      // asynchronous reset while loading
      drive(4'b1000);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (pnl.L) seen = 1'b1;
      end
      chk("load2_rise", seen, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_L",     pnl.L,     0);
      chk("arst_di",    pnl.di,    0);
      chk("arst_fast",  pnl.fast,  0);
      chk("arst_blink", pnl.blink, 0);
      chk("arst_up",    pnl.up,    1);
      drive(4'b0000);
      repeat (3) cyc();
      #2 rst_n = 1'b1;
      repeat (DEB + 4) cyc();
      chk("post_rst_ce",    pnl.ce,    0);
      chk("post_rst_blink", pnl.blink, 0);
      chk("post_rst_L",     pnl.L,     0);
      chk("post_rst_clr",   pnl.clr,   0);
      check_period("post_rst", TS + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
